// File: rtl/bmem_arbiter_if.sv
// Signal bundle joining the fetch and data requesters, the arbiter and the backing memory port.
// The arbiter takes the slave view; the requesters and memory together take the master view.
interface bmem_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LINE_W = 256;

    logic [ADDR_W-1:0] i_addr;
    logic [MASK_W-1:0] i_rmask;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic [ADDR_W-1:0] d_addr;
    logic [MASK_W-1:0] d_rmask;
    logic [MASK_W-1:0] d_wmask;
    logic [DATA_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic [ADDR_W-1:0] bmem_addr;
    logic [MASK_W-1:0] bmem_rmask;
    logic [MASK_W-1:0] bmem_wmask;
    logic [DATA_W-1:0] bmem_wdata;
    logic [LINE_W-1:0] bmem_rdata;
    logic              bmem_resp;

    logic              busy;

    modport slave (
        input  i_addr, i_rmask,
        output i_rdata, i_resp,
        input  d_addr, d_rmask, d_wmask, d_wdata,
        output d_rdata, d_resp,
        output bmem_addr, bmem_rmask, bmem_wmask, bmem_wdata,
        input  bmem_rdata, bmem_resp,
        output busy
    );

    modport master (
        output i_addr, i_rmask,
        input  i_rdata, i_resp,
        output d_addr, d_rmask, d_wmask, d_wdata,
        input  d_rdata, d_resp,
        input  bmem_addr, bmem_rmask, bmem_wmask, bmem_wdata,
        output bmem_rdata, bmem_resp,
        input  busy
    );
endinterface

// File: rtl/bmem_arbiter.sv
// Two-way arbiter sharing one backing-memory port between instruction fetch and the data unit.
// One transaction in flight; D-priority with a starvation guard, or plain round-robin.
module bmem_arbiter #(
    parameter bit          DATA_PRIORITY = 1'b1,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic          clk,
    input  logic          rst,
    bmem_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] rmask;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_e           state_q, state_d;
    logic             last_d_q, last_d_d;   // 1 = most recent grant went to D
    logic [CNT_W-1:0] starve_q, starve_d;
    req_t             req_q, req_d;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;

    assign i_req = |bus.i_rmask;
    assign d_req = (|bus.d_rmask) | (|bus.d_wmask);

    // Arbitration in IDLE; wait for the downstream completion otherwise.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        starve_d = starve_q;
        req_d    = req_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    if (DATA_PRIORITY) begin
                        grant_i = (starve_q == CNT_W'(STARVE_LIMIT));
                    end else begin
                        grant_i = last_d_q;
                    end
                    grant_d = ~grant_i;
                end else begin
                    grant_i = i_req;
                    grant_d = d_req;
                end

                if (grant_i) begin
                    state_d     = GNT_I;
                    last_d_d    = 1'b0;
                    starve_d    = '0;
                    req_d.addr  = bus.i_addr;
                    req_d.rmask = bus.i_rmask;
                    req_d.wmask = '0;
                    req_d.wdata = '0;
                end else if (grant_d) begin
                    state_d     = GNT_D;
                    last_d_d    = 1'b1;
                    req_d.addr  = bus.d_addr;
                    req_d.rmask = bus.d_rmask;
                    req_d.wmask = bus.d_wmask;
                    req_d.wdata = (|bus.d_wmask) ? bus.d_wdata : '0;
                    if (i_req && (starve_q != '1)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
            GNT_I, GNT_D: begin
                // Masks drop with the completion; address and data are kept.
                if (bus.bmem_resp) begin
                    state_d     = IDLE;
                    req_d.rmask = '0;
                    req_d.wmask = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            starve_q <= '0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            starve_q <= starve_d;
            req_q    <= req_d;
        end
    end

    assign bus.bmem_addr  = req_q.addr;
    assign bus.bmem_rmask = req_q.rmask;
    assign bus.bmem_wmask = req_q.wmask;
    assign bus.bmem_wdata = req_q.wdata;
    assign bus.busy       = (state_q != IDLE);

    // Completion is a same-cycle pass-through to whichever port owns the transaction.
    assign bus.i_resp  = (state_q == GNT_I) & bus.bmem_resp;
    assign bus.d_resp  = (state_q == GNT_D) & bus.bmem_resp;
    assign bus.i_rdata = bus.bmem_rdata;
    assign bus.d_rdata = bus.bmem_rdata;
endmodule

// File: doc/bmem_arbiter.md
Name: bmem_arbiter

Overview:
- Shares the single backing-memory port between two requesters: instruction fetch (port I, read-only) and the data memory unit (port D, read/write).
- Sits between the fetch stage/mem_unit and the bmem interface.
- Each requester drives the same addr/rmask/wmask/wdata request style and sees 256-bit rdata plus a resp pulse.
- Exactly one transaction is in flight downstream at a time.

Parameters:
DATA_PRIORITY, 1, 1 = port D wins ties (subject to starvation guard); 0 = strict round-robin
STARVE_LIMIT, 4, max consecutive D grants while I is waiting before I is forced (1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
i_addr  in  32  fetch request address
i_rmask  in  4  fetch read mask; nonzero = request pending
i_rdata  out  256  memory line to fetch
i_resp  out  1  one-cycle completion pulse to fetch
d_addr  in  32  data request address
d_rmask  in  4  data read mask
d_wmask  in  4  data write mask
d_wdata  in  32  data write data
d_rdata  out  256  memory line to data unit
d_resp  out  1  one-cycle completion pulse to data unit
bmem_addr  out  32  downstream address
bmem_rmask  out  4  downstream read mask
bmem_wmask  out  4  downstream write mask
bmem_wdata  out  32  downstream write data
bmem_rdata  in  256  downstream read line
bmem_resp  in  1  downstream completion pulse
busy  out  1  high while a downstream transaction is outstanding

Behaviour:
- Request definitions:
  - I request = |i_rmask.
  - D request = |d_rmask | |d_wmask.
  - Requesters hold addr, mask and data stable from assertion until their resp pulse.
  - d_rmask and d_wmask both nonzero is illegal; the arbiter forwards both unchanged.
- Reset (rst low, async): state=IDLE, last_grant=I, starve_cnt=0, request register cleared.
  - All outputs 0: bmem masks 0, i_resp/d_resp 0, busy 0.
  - Reset mid-transaction abandons the transaction. A bmem_resp arriving later while IDLE is ignored and is not forwarded.
- States:
  - IDLE: no transaction outstanding.
  - GNT_I: fetch transaction outstanding.
  - GNT_D: data transaction outstanding.
- IDLE, in a cycle with ≥1 request:
  - Choose the winner and latch its addr/masks/wdata into the request register.
  - Go to GNT_I or GNT_D; update last_grant.
  - Arbitration rule when both request:
    - DATA_PRIORITY=0: grant the port that is not last_grant.
    - DATA_PRIORITY=1: grant D unless starve_cnt==STARVE_LIMIT, in which case grant I.
  - Only one requester: grant it.
- starve_cnt:
  - Increments (saturating) on each D grant made while I is requesting.
  - Resets to 0 on any I grant.
  - Unchanged otherwise.
- GNT_x:
  - bmem_* driven from the request register.
  - Masks are held nonzero until the bmem_resp cycle inclusive.
  - busy=1.
- Downstream request visibility: the request appears on bmem the cycle after grant (one-cycle grant latency). bmem_resp is never expected in the grant cycle itself.
- On bmem_resp in GNT_x:
  - Pulse x_resp=1 for that same cycle (combinational pass-through).
  - Go to IDLE; bmem masks 0 from the next cycle.
  - The next grant can occur in that IDLE cycle, so back-to-back transactions have a 1-cycle IDLE gap.
- Response routing:
  - i_rdata and d_rdata are both wired to bmem_rdata at all times.
  - Only the owner's resp pulses; the non-owner's resp stays 0.
- Request withdrawal:
  - A requester dropping its mask while granted is illegal; the arbiter completes the transaction regardless.
  - A requester dropping its mask while waiting is legal; it is simply not granted.
- bmem_wdata is 0 for read grants. When not busy, bmem_addr/bmem_wdata hold the last registered value; masks are 0.

Test Plan:
- Reset then single I read, addr 0x60000000, rmask 0xF, bmem_resp 3 cycles after bmem_rmask rises → bmem_rmask=0xF one cycle after request; i_resp pulses with i_rdata=bmem_rdata; d_resp stays 0; busy clears the next cycle.
- D store, addr 0x1004, wmask 0xC, wdata 0xDEAD0000 → bmem_wmask=0xC and bmem_wdata=0xDEAD0000 held until resp; d_resp pulses once; bmem_rmask stays 0.
- DATA_PRIORITY=0, I and D requesting continuously → grants alternate D,I,D,I after a last I reset state; each separated by a 1-cycle IDLE gap.
- DATA_PRIORITY=1, STARVE_LIMIT=4, I and D requesting continuously → 4 D grants, then 1 I grant, then starve_cnt=0 and the pattern repeats.
- rst driven low while GNT_D with bmem_resp arriving 2 cycles after rst returns high → all outputs 0 immediately on reset; stray bmem_resp produces no i_resp/d_resp; state stays IDLE.
- Both requests arrive in the same cycle bmem_resp completes a prior D grant → d_resp pulses; the new grant goes to I in the following IDLE cycle under either parameter setting when starve_cnt permits.
